// File: rtl/clk_div_bank.sv
// Bank of independent integer clock dividers sharing one clock, with per-channel
// ratio updates that take effect only on a period boundary, plus a lock indicator.
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int         LCW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

    logic [DIV_W-1:0] d_act    [NUM_CH];
    logic [DIV_W-1:0] p        [NUM_CH];
    logic [DIV_W-1:0] pend_div [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] commit;
    logic [NUM_CH-1:0] wrap;
    logic [7:0]        pend_ext;
    logic              in_range;
    logic              accept;
    logic [LCW-1:0]    lock_cnt;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pend;
        in_range               = {1'b0, cfg_ch} < NUM_CH_L;
        // Out-of-range writes are always taken and dropped so the master never stalls.
        cfg_ready              = in_range ? ~pend_ext[cfg_ch] : 1'b1;
        accept                 = cfg_valid & cfg_ready & in_range;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]   = (p[i] == d_act[i] - DIV_W'(1));
            commit[i] = pend[i] & (~ch_en[i] | wrap[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_act[i] <= DIV_W'(DEF_DIV);
                p[i]     <= '0;
            end
            pend    <= '0;
            clk_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                clk_out[i] <= ch_en[i] & (p[i] < (d_act[i] >> 1));
                if (!ch_en[i] || wrap[i] || commit[i]) begin
                    p[i] <= '0;
                end else begin
                    p[i] <= p[i] + DIV_W'(1);
                end
                // Commit and accept are mutually exclusive: ready is low while pending.
                if (commit[i]) begin
                    d_act[i] <= pend_div[i];
                    pend[i]  <= 1'b0;
                end
                if (accept && cfg_ch == 3'(i)) begin
                    pend[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept && cfg_ch == 3'(i)) begin
                pend_div[i] <= clamp_div(cfg_div);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (accept || (|pend)) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LCW'(LOCK_CYCLES)) begin
            lock_cnt <= lock_cnt + LCW'(1);
        end
    end

    assign locked = (lock_cnt == LCW'(LOCK_CYCLES));

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: waveform shapes, boundary-aligned ratio commits,
// handshake back-pressure, lock recovery and reset behaviour.
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] clk_out;
    logic       locked;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_bank #(.NUM_CH(4), .DIV_W(8), .DEF_DIV(2), .LOCK_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_d5 [8] = '{1, 0, 1, 1, 0, 0, 0, 1};
    logic [7:0] seq_d6 [7] = '{1, 1, 1, 0, 0, 0, 1};

    initial begin
        rst = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) tick();
        check_eq("rst_clk_out", 32'(clk_out), 0);
        check_eq("rst_locked", 32'(locked), 0);

        // Channel 0 at the default ratio of 2, lock after 16 quiet cycles
        rst = 1'b0; ch_en = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq("ch0_d2", 32'(clk_out[0]), 32'(k % 2));
            if (k == 15) check_eq("lock_pre", 32'(locked), 0);
            if (k == 16) check_eq("lock_16", 32'(locked), 1);
        end

        // Channel 1: ratio 5 requested mid-period, commits at the period end
        ch_en = 4'b0011;
        tick();
        check_eq("ch1_a1", 32'(clk_out[1]), 1);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5;
        #1 check_eq("ch1_ready", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        #1 check_eq("ch1_busy", 32'(cfg_ready), 0);
        check_eq("ch1_lock_drop", 32'(locked), 0);
        check_eq("ch1_a2", 32'(clk_out[1]), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("ch1_d5_wave", 32'(clk_out[1]), 32'(seq_d5[k]));
            if (k == 1) check_eq("ch1_ready_commit", 32'(cfg_ready), 1);
        end
        for (int k = 11; k <= 20; k++) begin
            tick();
            if (k == 19) check_eq("ch1_lock_pre", 32'(locked), 0);
            if (k == 20) check_eq("ch1_lock_back", 32'(locked), 1);
        end

        // Channel 2: ratio 0 clamps to 2; second write is held off until commit
        ch_en = 4'b0111; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
        tick();
        check_eq("ch2_b1", 32'(clk_out[2]), 1);
        cfg_div = 8'd9;
        #1 check_eq("ch2_busy", 32'(cfg_ready), 0);
        tick();
        check_eq("ch2_b2", 32'(clk_out[2]), 0);
        check_eq("ch2_ready_commit", 32'(cfg_ready), 1);
        cfg_valid = 1'b0;
        tick();
        check_eq("ch2_b3", 32'(clk_out[2]), 1);
        tick();
        check_eq("ch2_b4", 32'(clk_out[2]), 0);
        repeat (14) tick();
        check_eq("ch2_lock_back", 32'(locked), 1);

        // Channel 3: ratio 6 written while disabled commits immediately
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd6;
        tick();
        cfg_valid = 1'b0;
        #1 check_eq("ch3_busy", 32'(cfg_ready), 0);
        tick();
        check_eq("ch3_ready", 32'(cfg_ready), 1);
        ch_en = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_eq("ch3_d6_wave", 32'(clk_out[3]), 32'(seq_d6[k]));
        end
        repeat (8) tick();
        check_eq("ch3_lock_pre", 32'(locked), 0);
        tick();
        check_eq("ch3_lock_back", 32'(locked), 1);

        // Out-of-range channel: accepted and dropped, lock undisturbed
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd3;
        #1 check_eq("oor_ready", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0; cfg_ch = 3'd0;
        check_eq("oor_lock1", 32'(locked), 1);
        #1 check_eq("oor_ch0_ready", 32'(cfg_ready), 1);
        tick();
        check_eq("oor_lock2", 32'(locked), 1);
        tick();
        check_eq("oor_ch3_wave", 32'(clk_out[3]), 1);

        // Reset with ch1 pending 7 and a concurrent ch0 handshake
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd7;
        tick();
        rst = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd9;
        tick();
        check_eq("mid_rst_clk_out", 32'(clk_out), 0);
        check_eq("mid_rst_locked", 32'(locked), 0);
        rst = 1'b0; cfg_valid = 1'b0; cfg_ch = 3'd1; ch_en = 4'b0011;
        #1 check_eq("mid_rst_ready", 32'(cfg_ready), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("post_rst_d2", 32'(clk_out), (k % 2 == 1) ? 32'h3 : 32'h0);
            if (k == 1) check_eq("post_rst_lock", 32'(locked), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divided-clock channels (1..8).
REQ-002 Parameter DIV_W, default 8, width of each channel's divide ratio.
REQ-003 Parameter DEF_DIV, default 2, divide ratio loaded into every channel at reset.
REQ-004 Parameter LOCK_CYCLES, default 16, number of consecutive quiet cycles required before `locked` asserts.
REQ-005 Port `clk`, input, 1 bit: the single clock. All logic SHALL be clocked on its rising edge.
REQ-006 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port `ch_en`, input, NUM_CH bits: per-channel run enable.
REQ-008 Port `cfg_valid`, input, 1 bit: a ratio-update request is present.
REQ-009 Port `cfg_ready`, output, 1 bit: the block can accept the update for `cfg_ch`.
REQ-010 Port `cfg_ch`, input, 3 bits: target channel index.
REQ-011 Port `cfg_div`, input, DIV_W bits: requested divide ratio.
REQ-012 Port `clk_out`, output, NUM_CH bits: divided clocks, each driven directly from a flop.
REQ-013 Port `locked`, output, 1 bit: all channels are running at their committed ratios.

Function
REQ-014 Phase counter per channel:
- Each channel SHALL hold an active ratio D and a phase counter p.
- While `ch_en[i]`=1, p SHALL increment every cycle and wrap from D-1 to 0.
- While `ch_en[i]`=0, p SHALL be held at 0 and `clk_out[i]` SHALL be 0.
REQ-015 Output waveform:
- `clk_out[i]` SHALL be 1 for p in [0, floor(D/2)) and 0 for p in [floor(D/2), D).
- Timing: the first cycle with `ch_en[i]` sampled 1 is p=0, and `clk_out[i]` rises on the following edge (one-cycle registered latency).
REQ-016 Ratio clamp: a `cfg_div` value of 0 or 1 SHALL be clamped to 2 when accepted.
REQ-017 Handshake:
- An update is accepted on a cycle where `cfg_valid`=1, `cfg_ready`=1 and `cfg_ch` < NUM_CH.
- An update with `cfg_ch` >= NUM_CH SHALL be accepted and discarded.
REQ-018 Pending register:
- Each channel SHALL have one pending-ratio register with a pending flag.
- `cfg_ready` SHALL be the inverse of the pending flag of the channel addressed by `cfg_ch` (combinational).
- `cfg_ready` SHALL be 1 when `cfg_ch` >= NUM_CH.
REQ-019 Commit rule:
- A pending ratio SHALL become the active D on the cycle where p=D-1 and `ch_en[i]`=1, or on any cycle where `ch_en[i]`=0.
- On commit, p restarts at 0 and the pending flag clears.
- A period is never truncated.
REQ-020 Simultaneous accept and commit on the same channel cannot occur: `cfg_ready` is 0 while that channel's flag is set.
REQ-021 Alignment: channels enabled on the same cycle with equal D SHALL produce identical `clk_out` bits thereafter.
REQ-022 Lock counter:
- `locked` SHALL drop to 0 on the cycle after any accepted in-range update.
- It SHALL return to 1 after LOCK_CYCLES consecutive cycles in which no pending flag is set and no update is accepted.
- The lock counter SHALL saturate at LOCK_CYCLES.
REQ-023 Enable toggling alone SHALL NOT affect `locked`.

Reset
REQ-024 With `rst`=1 at a rising edge:
- All active D SHALL be set to DEF_DIV.
- All p, pending flags and the lock counter SHALL be cleared.
- `clk_out` SHALL be all 0 and `locked` SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard pending ratios and SHALL override a simultaneous handshake.
REQ-026 After `rst` deasserts, `locked` SHALL assert LOCK_CYCLES cycles later with no updates.

Verification
REQ-027 Reset, then `ch_en`=4'b0001 held -> `clk_out[0]` toggles 1,0 every cycle (period 2); `locked`=1 at the 16th cycle after reset release.
REQ-028 Write ch1 `cfg_div`=5, ch1 enabled -> `clk_out[1]` high 2 cycles, low 3 cycles; new ratio starts only after the current period completes; `locked` drops, then recovers 16 cycles after commit.
REQ-029 Write ch2 `cfg_div`=0 -> ch2 runs at D=2; a second write to ch2 before commit sees `cfg_ready`=0 until the commit cycle.
REQ-030 Write ch3 `cfg_div`=6 while `ch_en[3]`=0 -> commits the next cycle; enabling ch3 gives 3 high, 3 low.
REQ-031 Assert `rst` while ch1 has pending ratio 7 -> `clk_out` goes to 0 on the next edge; after release ch1 runs at D=2.
REQ-032 Write with `cfg_ch`=5 -> handshake completes, no channel changes, `locked` stays 1.
